// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants: register file, destination mux and control unit.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/placar_registradores.sv
// Pending-write scoreboard: decode sets a bit at issue, writeback clears it, stall on pending sources.
// WRITE_BYPASS_EN lets a completing writeback hide the hazard in the same cycle.
module placar_registradores
    import mips_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  logic             iss_valid,
    input  reg_addr_t        iss_addr,
    input  reg_addr_t        rs_addr,
    input  reg_addr_t        rt_addr,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic [NREGS-1:0] pend_vec
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pendNext;
    logic             clrRs;
    logic             clrRt;

    always_comb begin
`ifdef WRITE_BYPASS_EN
        clrRs = wr_en && (wr_addr == rs_addr);
        clrRt = wr_en && (wr_addr == rt_addr);
`else
        clrRs = 1'b0;
        clrRt = 1'b0;
`endif
        stall = (rs_used && pend[rs_addr] && !clrRs) ||
                (rt_used && pend[rt_addr] && !clrRt);
    end

    // Set is applied after clear so a new producer of the same register wins.
    always_comb begin
        pendNext = pend;
        if (wr_en)
            pendNext[wr_addr] = 1'b0;
        if (iss_valid && !stall && (iss_addr != REG_ZERO))
            pendNext[iss_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pend <= '0;
        else
            pend <= pendNext;
    end

    assign pend_vec = pend;

endmodule

// File: rtl/banco_registradores.sv
// MIPS 32x32 register file: two combinational read ports, one write port, pending-write scoreboard.
// Optional macro WRITE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module banco_registradores
    import mips_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  reg_addr_t        rs_addr,
    input  reg_addr_t        rt_addr,
    output word_t            rs_data,
    output word_t            rt_data,
    input  logic             wr_en,
    input  reg_addr_t        wr_addr,
    input  word_t            wr_data,
    input  logic             iss_valid,
    input  reg_addr_t        iss_addr,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic [NREGS-1:0] pend_vec
);

    word_t regs [NREGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads are forced to zero while reset is held so bypassed data cannot leak out.
    always_comb begin
        rs_data = regs[rs_addr];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (wr_addr == rs_addr))
            rs_data = wr_data;
`endif
        if (!reset_n || (rs_addr == REG_ZERO))
            rs_data = '0;
    end

    always_comb begin
        rt_data = regs[rt_addr];
`ifdef WRITE_BYPASS_EN
        if (wr_en && (wr_addr == rt_addr))
            rt_data = wr_data;
`endif
        if (!reset_n || (rt_addr == REG_ZERO))
            rt_data = '0;
    end

    placar_registradores uPlacar (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .stall     (stall),
        .pend_vec  (pend_vec)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores: stimulus queues expectations, negedge monitor checks them.
module tb_banco_registradores;

`ifdef WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_RS    = 0;
    localparam int SEL_RT    = 1;
    localparam int SEL_STALL = 2;
    localparam int SEL_PEND  = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr, iss_addr;
    logic [31:0] rs_data, rt_data, wr_data, pend_vec;
    logic        wr_en, iss_valid, rs_used, rt_used, stall;

    banco_registradores dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .stall     (stall),
        .pend_vec  (pend_vec)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        mon;
    logic [31:0] act;
    int          cycle = 0;
    int          compared = 0;
    int          mismatched = 0;

    always @(posedge clock) cycle <= cycle + 1;

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cycle) begin
            mon = q.pop_front();
            case (mon.sel)
                SEL_RS:    act = rs_data;
                SEL_RT:    act = rt_data;
                SEL_STALL: act = {31'd0, stall};
                default:   act = pend_vec;
            endcase
            compared++;
            if (mon.cyc != cycle || act !== mon.val) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", mon.name, act, mon.val, cycle);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pushExp(input int sel, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cycle;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_addr  = a;
    endtask

    initial begin
        reset_n = 1'b0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0; iss_addr = '0;
        wr_data = '0; wr_en = 1'b0; iss_valid = 1'b0;
        rs_used = 1'b0; rt_used = 1'b0;

        step(); step();
        rs_addr = 5'd31; rt_addr = 5'd5;
        pushExp(SEL_RS, 0, "rst_rs");
        pushExp(SEL_RT, 0, "rst_rt");
        pushExp(SEL_STALL, 0, "rst_stall");
        pushExp(SEL_PEND, 0, "rst_pend");
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step();
            rs_addr = 5'(i);
            rt_addr = 5'(i + 16);
            pushExp(SEL_RS, 0, "post_rst_rs");
            pushExp(SEL_RT, 0, "post_rst_rt");
        end
        pushExp(SEL_PEND, 0, "post_rst_pend");
        pushExp(SEL_STALL, 0, "post_rst_stall");

        // jal destination and r0 write discard
        step(); wr(5'd31, 32'hDEADBEEF); rs_addr = 5'd31;
        pushExp(SEL_RS, BYP ? 32'hDEADBEEF : 32'h0, "r31_same_cycle");
        step(); wr_en = 1'b0;
        pushExp(SEL_RS, 32'hDEADBEEF, "r31_read");
        step(); wr(5'd0, 32'h12345678); rs_addr = 5'd0;
        pushExp(SEL_RS, 0, "r0_same_cycle");
        step(); wr_en = 1'b0;
        pushExp(SEL_RS, 0, "r0_read");

        step(); wr(5'd1, 32'h11);
        step(); wr(5'd2, 32'h22);
        step(); wr_en = 1'b0; rs_addr = 5'd1; rt_addr = 5'd2;
        pushExp(SEL_RS, 32'h11, "r1_read");
        pushExp(SEL_RT, 32'h22, "r2_read");

        // RAW on r8 through rs
        step(); iss(5'd8);
        pushExp(SEL_STALL, 0, "iss8_nostall");
        step(); iss_valid = 1'b0; rs_addr = 5'd8; rs_used = 1'b1;
        pushExp(SEL_STALL, 1, "r8_stall");
        pushExp(SEL_PEND, 32'h100, "r8_pend");
        step();
        pushExp(SEL_STALL, 1, "r8_stall_hold");
        step(); wr(5'd8, 32'h55);
        pushExp(SEL_STALL, BYP ? 32'h0 : 32'h1, "r8_wb_stall");
        pushExp(SEL_RS, BYP ? 32'h55 : 32'h0, "r8_wb_data");
        step(); wr_en = 1'b0;
        pushExp(SEL_STALL, 0, "r8_after_wb_stall");
        pushExp(SEL_PEND, 0, "r8_after_wb_pend");
        pushExp(SEL_RS, 32'h55, "r8_after_wb_data");
        rs_used = 1'b0;

        // RAW on r12 through rt, with use-flag gating
        step(); iss(5'd12);
        step(); iss_valid = 1'b0; rs_addr = 5'd12; rt_addr = 5'd12;
        pushExp(SEL_STALL, 0, "r12_unused_src");
        step(); rt_used = 1'b1;
        pushExp(SEL_STALL, 1, "r12_rt_stall");
        step(); wr(5'd12, 32'h00C0FFEE);
        pushExp(SEL_STALL, BYP ? 32'h0 : 32'h1, "r12_wb_stall");
        step(); wr_en = 1'b0; rt_used = 1'b0;
        pushExp(SEL_PEND, 0, "r12_pend_clear");
        pushExp(SEL_RT, 32'h00C0FFEE, "r12_read");

        // same-register set and clear: set wins
        step(); iss(5'd9);
        step(); iss(5'd9); wr(5'd9, 32'h99);
        step(); iss_valid = 1'b0; wr_en = 1'b0; rs_addr = 5'd9;
        pushExp(SEL_PEND, 32'h200, "r9_set_wins");
        pushExp(SEL_RS, 32'h99, "r9_written");
        // different registers: both apply
        step(); iss(5'd11); wr(5'd9, 32'h9A);
        step(); iss_valid = 1'b0; wr_en = 1'b0;
        pushExp(SEL_PEND, 32'h800, "set11_clr9");
        pushExp(SEL_RS, 32'h9A, "r9_rewritten");
        step(); wr(5'd11, 32'hB);
        step(); wr_en = 1'b0;
        pushExp(SEL_PEND, 0, "r11_clear");

        // issue blocked while stalled
        step(); iss(5'd13);
        step(); rs_addr = 5'd13; rs_used = 1'b1; iss(5'd10);
        pushExp(SEL_STALL, 1, "r13_stall");
        step(); iss_valid = 1'b0;
        pushExp(SEL_PEND, 32'h2000, "r10_not_set");
        step(); wr(5'd13, 32'h13); rs_used = 1'b0;
        step(); wr_en = 1'b0;
        pushExp(SEL_PEND, 0, "r13_clear");

        step(); iss(5'd0);
        step(); iss_valid = 1'b0;
        pushExp(SEL_PEND, 0, "r0_never_pending");

        // asynchronous reset mid-operation
        step(); wr(5'd3, 32'h33);
        step(); wr(5'd4, 32'h44);
        step(); wr_en = 1'b0; iss(5'd3);
        step(); iss(5'd4);
        step(); iss_valid = 1'b0; rs_addr = 5'd3; rt_addr = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
        pushExp(SEL_PEND, 32'h18, "r3_r4_pend");
        pushExp(SEL_STALL, 1, "r3_r4_stall");
        pushExp(SEL_RS, 32'h33, "r3_before_rst");
        step();
        pushExp(SEL_PEND, 0, "async_rst_pend");
        pushExp(SEL_RS, 0, "async_rst_r3");
        pushExp(SEL_RT, 0, "async_rst_r4");
        pushExp(SEL_STALL, 0, "async_rst_stall");
        #2 reset_n = 1'b0;
        step(); reset_n = 1'b1; rs_used = 1'b0; rt_used = 1'b0; rs_addr = 5'd31;
        pushExp(SEL_RS, 0, "post_rst_r31");
        step(); wr(5'd7, 32'h77);
        step(); wr_en = 1'b0; rs_addr = 5'd7; rt_addr = 5'd3;
        pushExp(SEL_RS, 32'h77, "post_rst_write");
        pushExp(SEL_RT, 0, "post_rst_r3");
        pushExp(SEL_PEND, 0, "post_rst_pend2");

        for (int k = 0; k < 10 && q.size() > 0; k++) step();
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- MIPS integer register file: 32 x 32-bit, two combinational read ports (rs, rt) and one synchronous write port.
- Sits downstream of the write-destination select logic. It takes the final 5-bit destination (rd/rt, or 31 for jal) plus write data and enable from writeback.
- Contains a per-register pending-write scoreboard. Decode marks a destination pending at issue; writeback clears it. A stall is raised when a source operand is still pending.

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of architectural registers; must be 32 for MIPS
- ADDR_W, 5, register address width = log2(NREGS)

Ports:
- clock  input  1  single system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset; released synchronously by the system
- rs_addr  input  5  read port A address
- rt_addr  input  5  read port B address
- rs_data  output 32  read port A data
- rt_data  output 32  read port B data
- wr_en  input  1  writeback write enable
- wr_addr  input  5  writeback destination (already resolved, 31 for jal)
- wr_data  input  32  writeback data
- iss_valid  input  1  decode is issuing an instruction that will write a register
- iss_addr  input  5  destination of the issuing instruction
- rs_used  input  1  issuing instruction reads rs
- rt_used  input  1  issuing instruction reads rt
- stall  output 1  hazard: a used source is pending; decode must hold
- pend_vec  output 32  scoreboard contents, bit i = register i pending (debug/verification)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all 32 registers cleared to 0
  - pend_vec = 0, stall = 0
  - rs_data/rt_data = 0 during reset
- Register 0:
  - always reads 0
  - writes to address 0 are discarded
  - never marked pending: iss_addr=0 does not set pend bit 0
- Write:
  - on rising clock, if wr_en=1 and wr_addr!=0, then regs[wr_addr] <= wr_data
  - one write per cycle
- Read:
  - combinational, zero latency: rs_data = regs[rs_addr], rt_data = regs[rt_addr]
  - same-cycle write to the read address is governed by the optional feature
- Scoreboard, on each rising clock:
  - clear: if wr_en=1, pend[wr_addr] <= 0
  - set: if iss_valid=1 and stall=0 and iss_addr!=0, pend[iss_addr] <= 1
  - set and clear on the same register in the same cycle: set wins, bit stays 1 (new in-order producer replaces the old one)
  - set and clear on different registers: both apply
  - iss_valid while stall=1: no set; decode re-presents next cycle
- Stall (combinational):
  - stall = (rs_used & pend[rs_addr] & ~clr_rs) | (rt_used & pend[rt_addr] & ~clr_rt)
  - clr_x = wr_en & (wr_addr == x_addr), i.e. a writeback completing this cycle removes the hazard only when the bypass makes the data visible
  - without WRITE_BYPASS_EN, clr_x = 0
- Boundaries:
  - all 32 bits pending is legal (no full condition)
  - wr_en to a non-pending register is legal (no error); the bit stays 0
  - reset asserted mid-operation: all state clears immediately; the first cycle after release behaves as post-reset

Optional Feature:
- Macro: WRITE_BYPASS_EN
- Defined:
  - if wr_en=1, wr_addr!=0 and wr_addr equals a read address, that read port returns wr_data in the same cycle
  - stall discounts that register via clr_x
- Undefined:
  - reads return the pre-write register value
  - stall holds until the cycle after writeback
  - one extra bubble per RAW hazard

Decomposition:
- Shared package (mips_pkg) holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31
  - DATA_W, ADDR_W constants
  - reg_addr_t / word_t typedefs
  - shared with the destination mux and the control unit
- One natural sub-module, placar_registradores: the 32-bit scoreboard with set/clear priority and stall generation. Storage array and read muxes stay in the top.

Test Plan:
- Reset then read all 32 addresses -> every read 0; pend_vec=0; stall=0.
- Write 0xDEADBEEF to r31 (jal destination), next cycle read rs_addr=31 -> 0xDEADBEEF; write 0x12345678 to r0 -> r0 still reads 0.
- iss_valid, iss_addr=8; next cycle rs_addr=8, rs_used=1 -> stall=1, pend_vec=0x100; wr_en to r8 with 0x55 -> with bypass, stall=0 and rs_data=0x55 that cycle; without bypass, stall drops one cycle later.
- Same cycle: wr_en wr_addr=9 and iss_valid iss_addr=9 -> pend bit 9 remains 1; regs[9] updated.
- iss_valid while stall=1 (iss_addr=10) -> pend bit 10 not set.
- Mark r3, r4 pending, assert reset_n=0 mid-cycle -> pend_vec=0 and r3/r4 read 0 immediately, without waiting for a clock edge.
